pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges three hazard sources into one set of per-stage enable and flush controls:
- load-use hazards, with a configurable bubble count;
- EX-stage control-flow redirects;
- multi-cycle data-memory waits, with a timeout watchdog.

It sits beside the ID/EX/MEM pipeline registers and drives their enable and flush pins.

---
 rtl/pipeline_stall_ctrl_if.sv | 57 +++++
 rtl/pipeline_stall_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// sequencer. The datapath side (master) presents the ID/EX instructions and
// the redirect and data-memory handshake. The sequencer side (slave) returns
// the per-stage enables, flushes, the timeout pulse and the stall counter.
interface pipeline_stall_ctrl_if;
    logic [31:0] inst_ID_i;
    logic [31:0] inst_EX_i;
    logic        br_redirect_EX_i;
    logic        dmem_req_MEM_i;
    logic        dmem_ack_i;

    logic        pc_en_o;
    logic        IF_ID_en_o;
    logic        ID_EX_en_o;
    logic        EX_MEM_en_o;
    logic        IF_ID_flush_o;
    logic        ID_EX_flush_o;
    logic        MEM_WB_flush_o;
    logic        dmem_err_o;
    logic [31:0] stall_cnt_o;

    // Datapath side: drives the hazard sources and consumes the controls.
    modport master (
        output inst_ID_i,
        output inst_EX_i,
        output br_redirect_EX_i,
        output dmem_req_MEM_i,
        output dmem_ack_i,
        input  pc_en_o,
        input  IF_ID_en_o,
        input  ID_EX_en_o,
        input  EX_MEM_en_o,
        input  IF_ID_flush_o,
        input  ID_EX_flush_o,
        input  MEM_WB_flush_o,
        input  dmem_err_o,
        input  stall_cnt_o
    );

    // Sequencer side: consumes the hazard sources and drives the controls.
    modport slave (
        input  inst_ID_i,
        input  inst_EX_i,
        input  br_redirect_EX_i,
        input  dmem_req_MEM_i,
        input  dmem_ack_i,
        output pc_en_o,
        output IF_ID_en_o,
        output ID_EX_en_o,
        output EX_MEM_en_o,
        output IF_ID_flush_o,
        output ID_EX_flush_o,
        output MEM_WB_flush_o,
        output dmem_err_o,
        output stall_cnt_o
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage RISC-V pipeline.
// Merges data-memory waits (with a watchdog), EX-stage redirects and
// load-use hazards into per-stage enable/flush controls. Controls are
// combinational from the current state and inputs; state and counters
// advance on the rising clock edge.
module pipeline_stall_ctrl #(
    parameter int LU_BUBBLES = 1,   // bubbles per load-use hazard, 1..3
    parameter int TIMEOUT    = 255  // max consecutive wait cycles, 1..65535
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pipeline_stall_ctrl_if.slave ctrl
);

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT);
    // Bubble counter preload; only meaningful when more than one bubble is
    // configured (the first bubble is issued from RUN).
    localparam logic [1:0]  BUB_LOAD   = 2'(LU_BUBBLES - 2);
    localparam bit          MULTI_BUB  = (LU_BUBBLES > 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t      state_reg,     state_next;
    logic [1:0]  bub_cnt_reg,   bub_cnt_next;
    logic        lu_pend_reg,   lu_pend_next;   // bubbles parked during a wait
    logic [15:0] wait_cnt_reg,  wait_cnt_next;
    logic [31:0] stall_cnt_reg, stall_cnt_next;

    // Instruction fields
    logic [6:0] ex_opcode;
    logic [4:0] ex_rd;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;

    // Hazard qualifiers
    logic       mem_active;
    logic       wait_pending;
    logic       timeout_hit;
    logic       freeze;
    state_t     eff_state;
    logic       in_bubble;

    // Controls
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_wb_flush;

    // Instruction bits outside the decoded fields are not needed here.
    logic       unused_inst_bits;
    assign unused_inst_bits = ^{ctrl.inst_EX_i[31:12],
                                ctrl.inst_ID_i[31:25],
                                ctrl.inst_ID_i[14:7]};

    assign ex_opcode = ctrl.inst_EX_i[6:0];
    assign ex_rd     = ctrl.inst_EX_i[11:7];
    assign id_opcode = ctrl.inst_ID_i[6:0];
    assign id_rs1    = ctrl.inst_ID_i[19:15];
    assign id_rs2    = ctrl.inst_ID_i[24:20];

    // Load-use detect: a load in EX writing a register the ID instruction reads.
    always_comb begin
        rs1_used = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) ||
                     (id_opcode == OP_JAL));
        rs2_used = (id_opcode == OP_REG) || (id_opcode == OP_STORE) ||
                   (id_opcode == OP_BRANCH);
        load_use = (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                   ((rs1_used && (id_rs1 == ex_rd)) ||
                    (rs2_used && (id_rs2 == ex_rd)));
    end

    // Freeze/watchdog qualification and the state the release cycle acts as.
    always_comb begin
        mem_active   = ctrl.dmem_req_MEM_i || (state_reg == ST_MEM_WAIT);
        wait_pending = mem_active && !ctrl.dmem_ack_i;
        // A timeout stands in for the ack; a real ack in the same cycle wins
        // because wait_pending is already low then.
        timeout_hit  = wait_pending && (wait_cnt_reg == TIMEOUT_W);
        freeze       = wait_pending && !timeout_hit;

        // On release from a wait, the cycle behaves as the state that was
        // interrupted, so parked bubbles or a held load-use act immediately.
        if (state_reg == ST_MEM_WAIT) begin
            eff_state = lu_pend_reg ? ST_LU_STALL : ST_RUN;
        end else begin
            eff_state = state_reg;
        end
        in_bubble = (eff_state == ST_LU_STALL) ||
                    ((eff_state == ST_RUN) && load_use);
    end

    // Prioritised per-stage controls: freeze, redirect, bubble, default.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ctrl.br_redirect_EX_i) begin
            // ID holds a wrong-path instruction, so any load-use is moot.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (in_bubble) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // Next-state, bubble counter, watchdog and stall counter.
    always_comb begin
        state_next     = state_reg;
        bub_cnt_next   = bub_cnt_reg;
        lu_pend_next   = lu_pend_reg;
        wait_cnt_next  = wait_cnt_reg;
        stall_cnt_next = stall_cnt_reg;

        if (freeze) begin
            state_next    = ST_MEM_WAIT;
            wait_cnt_next = wait_cnt_reg + 16'd1;
            // Park the remaining bubbles; a load-use seen from RUN is simply
            // re-detected from the held instructions after release.
            case (state_reg)
                ST_LU_STALL: lu_pend_next = 1'b1;
                ST_MEM_WAIT: lu_pend_next = lu_pend_reg;
                default:     lu_pend_next = 1'b0;
            endcase
        end else begin
            wait_cnt_next = 16'd0;
            lu_pend_next  = 1'b0;
            if (ctrl.br_redirect_EX_i) begin
                state_next = ST_RUN;
            end else if (eff_state == ST_LU_STALL) begin
                if (bub_cnt_reg == 2'd0) begin
                    state_next = ST_RUN;
                end else begin
                    state_next   = ST_LU_STALL;
                    bub_cnt_next = bub_cnt_reg - 2'd1;
                end
            end else if (load_use && MULTI_BUB) begin
                state_next   = ST_LU_STALL;
                bub_cnt_next = BUB_LOAD;
            end else begin
                state_next = ST_RUN;
            end
        end

        if (!pc_en && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_next = stall_cnt_reg + 32'd1;
        end
    end

    // State and counter registers; reset abandons any stall or wait.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= ST_RUN;
            bub_cnt_reg   <= 2'd0;
            lu_pend_reg   <= 1'b0;
            wait_cnt_reg  <= 16'd0;
            stall_cnt_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            bub_cnt_reg   <= bub_cnt_next;
            lu_pend_reg   <= lu_pend_next;
            wait_cnt_reg  <= wait_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign ctrl.pc_en_o        = pc_en;
    assign ctrl.IF_ID_en_o     = if_id_en;
    assign ctrl.ID_EX_en_o     = id_ex_en;
    assign ctrl.EX_MEM_en_o    = ex_mem_en;
    assign ctrl.IF_ID_flush_o  = if_id_flush;
    assign ctrl.ID_EX_flush_o  = id_ex_flush;
    assign ctrl.MEM_WB_flush_o = mem_wb_flush;
    assign ctrl.dmem_err_o     = timeout_hit;
    assign ctrl.stall_cnt_o    = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl. Two instances: A with one
// load-use bubble and TIMEOUT=5, B with three bubbles and the default
// timeout. Control word packing: {pc, IF_ID_en, ID_EX_en, EX_MEM_en,
// IF_ID_flush, ID_EX_flush, MEM_WB_flush}.
module tb_pipeline_stall_ctrl;

    localparam logic [6:0]  NORMAL = 7'b1111_000;
    localparam logic [6:0]  FREEZE = 7'b0000_001;
    localparam logic [6:0]  REDIR  = 7'b1111_110;
    localparam logic [6:0]  BUBBLE = 7'b0011_010;

    localparam logic [31:0] NOP     = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] LW5     = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] LW0     = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD_R1  = 32'h0072_8333; // add  x6,x5,x7
    localparam logic [31:0] ADD_R2  = 32'h0053_8333; // add  x6,x7,x5
    localparam logic [31:0] ADD_X0  = 32'h0070_0333; // add  x6,x0,x7
    localparam logic [31:0] LUI5    = 32'h0002_82B7; // lui  x5,0x28 (rs1 field = 5)
    localparam logic [31:0] ADDI5   = 32'h0053_8313; // addi x6,x7,5 (rs2 field = 5)

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if if_a ();
    pipeline_stall_ctrl_if if_b ();

    pipeline_stall_ctrl #(.LU_BUBBLES(1), .TIMEOUT(5)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_a_n),
        .ctrl   (if_a)
    );

    pipeline_stall_ctrl #(.LU_BUBBLES(3), .TIMEOUT(255)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_b_n),
        .ctrl   (if_b)
    );

    logic [6:0] ctl_a;
    logic [6:0] ctl_b;
    assign ctl_a = {if_a.pc_en_o, if_a.IF_ID_en_o, if_a.ID_EX_en_o, if_a.EX_MEM_en_o,
                    if_a.IF_ID_flush_o, if_a.ID_EX_flush_o, if_a.MEM_WB_flush_o};
    assign ctl_b = {if_b.pc_en_o, if_b.IF_ID_en_o, if_b.ID_EX_en_o, if_b.EX_MEM_en_o,
                    if_b.IF_ID_flush_o, if_b.ID_EX_flush_o, if_b.MEM_WB_flush_o};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s val=0x%0h", tag, got);
        end
    endtask

    task automatic drive_a(input logic [31:0] ex, input logic [31:0] id,
                           input logic redir, input logic req, input logic ack);
        if_a.inst_EX_i        = ex;
        if_a.inst_ID_i        = id;
        if_a.br_redirect_EX_i = redir;
        if_a.dmem_req_MEM_i   = req;
        if_a.dmem_ack_i       = ack;
    endtask

    task automatic drive_b(input logic [31:0] ex, input logic [31:0] id,
                           input logic redir, input logic req, input logic ack);
        if_b.inst_EX_i        = ex;
        if_b.inst_ID_i        = id;
        if_b.br_redirect_EX_i = redir;
        if_b.dmem_req_MEM_i   = req;
        if_b.dmem_ack_i       = ack;
    endtask

    // Let combinational outputs settle, mid-cycle.
    task automatic settle;
        #2;
    endtask

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        drive_a(NOP, NOP, 1'b0, 1'b0, 1'b0);
        drive_b(NOP, NOP, 1'b0, 1'b0, 1'b0);
        step;
        settle;
        check_val("a_rst_ctl",   32'(ctl_a), 32'(NORMAL));
        check_val("a_rst_cnt",   if_a.stall_cnt_o, 32'd0);
        check_val("a_rst_err",   32'(if_a.dmem_err_o), 32'd0);
        check_val("b_rst_ctl",   32'(ctl_b), 32'(NORMAL));
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        step;

        // ---- A: single-bubble load-use and its non-hazard variants ----
        drive_a(LW5, ADD_R1, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_lu_rs1_ctl", 32'(ctl_a), 32'(BUBBLE)); step;
        drive_a(NOP, ADD_R1, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_lu_after_ctl", 32'(ctl_a), 32'(NORMAL));
        check_val("a_lu_cnt", if_a.stall_cnt_o, 32'd1); step;
        drive_a(LW0, ADD_X0, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_rd_x0_ctl", 32'(ctl_a), 32'(NORMAL)); step;
        drive_a(LW5, LUI5, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_lui_ctl", 32'(ctl_a), 32'(NORMAL)); step;
        drive_a(LW5, ADDI5, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_addi_rs2_ctl", 32'(ctl_a), 32'(NORMAL)); step;
        drive_a(LW5, ADD_R2, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_lu_rs2_ctl", 32'(ctl_a), 32'(BUBBLE)); step;
        drive_a(NOP, NOP, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_lu_rs2_cnt", if_a.stall_cnt_o, 32'd2); step;

        // ---- A: redirect beats load-use, no bubble follows ----
        drive_a(LW5, ADD_R1, 1'b1, 1'b0, 1'b0); settle;
        check_val("a_redir_lu_ctl", 32'(ctl_a), 32'(REDIR)); step;
        drive_a(NOP, NOP, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_redir_next_ctl", 32'(ctl_a), 32'(NORMAL));
        check_val("a_redir_cnt", if_a.stall_cnt_o, 32'd2); step;

        // ---- A: ack with req -> no freeze ----
        drive_a(NOP, NOP, 1'b0, 1'b1, 1'b1); settle;
        check_val("a_ack0_ctl", 32'(ctl_a), 32'(NORMAL)); step;

        // ---- A: four wait cycles with a redirect held throughout ----
        for (int i = 0; i < 4; i++) begin
            drive_a(NOP, NOP, 1'b1, 1'b1, 1'b0); settle;
            check_val($sformatf("a_wait4_c%0d", i + 1), {24'd0, ctl_a, if_a.dmem_err_o},
                      {24'd0, FREEZE, 1'b0});
            step;
        end
        drive_a(NOP, NOP, 1'b1, 1'b1, 1'b1); settle;
        check_val("a_wait4_release", {24'd0, ctl_a, if_a.dmem_err_o}, {24'd0, REDIR, 1'b0}); step;
        drive_a(NOP, NOP, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_wait4_after_ctl", 32'(ctl_a), 32'(NORMAL));
        check_val("a_wait4_cnt", if_a.stall_cnt_o, 32'd6);

        // ---- A: reset, then timeout with req held ----
        rst_a_n = 1'b0; settle;
        check_val("a_rst2_cnt", if_a.stall_cnt_o, 32'd0);
        rst_a_n = 1'b1; step;
        for (int i = 0; i < 5; i++) begin
            drive_a(NOP, NOP, 1'b0, 1'b1, 1'b0); settle;
            check_val($sformatf("a_to_c%0d", i + 1), {24'd0, ctl_a, if_a.dmem_err_o},
                      {24'd0, FREEZE, 1'b0});
            step;
        end
        settle;
        check_val("a_to_c6_release", {24'd0, ctl_a, if_a.dmem_err_o}, {24'd0, NORMAL, 1'b1}); step;
        settle;
        check_val("a_to_c7_refreeze", {24'd0, ctl_a, if_a.dmem_err_o}, {24'd0, FREEZE, 1'b0}); step;
        settle;
        check_val("a_to_cnt", if_a.stall_cnt_o, 32'd6);

        // ---- A: reset while in MEM_WAIT (req dropped, no ack) ----
        drive_a(NOP, NOP, 1'b0, 1'b0, 1'b0); settle;
        check_val("a_memwait_hold_ctl", 32'(ctl_a), 32'(FREEZE));
        rst_a_n = 1'b0; settle;
        check_val("a_rst_wait_ctl", 32'(ctl_a), 32'(NORMAL));
        check_val("a_rst_wait_cnt", if_a.stall_cnt_o, 32'd0);
        step;
        rst_a_n = 1'b1; step; settle;
        check_val("a_rst_wait_next_ctl", 32'(ctl_a), 32'(NORMAL));
        check_val("a_rst_wait_next_cnt", if_a.stall_cnt_o, 32'd0);
        step;

        // ---- A: ack arriving on the timeout cycle counts as ack ----
        for (int i = 0; i < 5; i++) begin
            drive_a(NOP, NOP, 1'b0, 1'b1, 1'b0); step;
        end
        drive_a(NOP, NOP, 1'b0, 1'b1, 1'b1); settle;
        check_val("a_ack_on_to", {24'd0, ctl_a, if_a.dmem_err_o}, {24'd0, NORMAL, 1'b0}); step;
        drive_a(NOP, NOP, 1'b0, 1'b0, 1'b0); step;

        // ---- B: three-bubble load-use ----
        drive_b(LW5, ADD_R1, 1'b0, 1'b0, 1'b0); settle;
        check_val("b_lu_c1", 32'(ctl_b), 32'(BUBBLE)); step;
        drive_b(NOP, ADD_R1, 1'b0, 1'b0, 1'b0); settle;
        check_val("b_lu_c2", 32'(ctl_b), 32'(BUBBLE)); step;
        settle;
        check_val("b_lu_c3", 32'(ctl_b), 32'(BUBBLE)); step;
        settle;
        check_val("b_lu_c4", 32'(ctl_b), 32'(NORMAL));
        check_val("b_lu_cnt", if_b.stall_cnt_o, 32'd3); step;

        // ---- B: freeze in the middle of LU_STALL, bubbles resume ----
        drive_b(LW5, ADD_R1, 1'b0, 1'b0, 1'b0); settle;
        check_val("b_lufz_c1", 32'(ctl_b), 32'(BUBBLE)); step;
        drive_b(NOP, ADD_R1, 1'b0, 1'b1, 1'b0); settle;
        check_val("b_lufz_c2", 32'(ctl_b), 32'(FREEZE)); step;
        drive_b(NOP, ADD_R1, 1'b0, 1'b1, 1'b1); settle;
        check_val("b_lufz_c3", 32'(ctl_b), 32'(BUBBLE)); step;
        drive_b(NOP, ADD_R1, 1'b0, 1'b0, 1'b0); settle;
        check_val("b_lufz_c4", 32'(ctl_b), 32'(BUBBLE)); step;
        settle;
        check_val("b_lufz_c5", 32'(ctl_b), 32'(NORMAL));
        check_val("b_lufz_cnt", if_b.stall_cnt_o, 32'd7); step;

        // ---- B: reset during LU_STALL ----
        drive_b(LW5, ADD_R1, 1'b0, 1'b0, 1'b0); settle;
        check_val("b_rlu_c1", 32'(ctl_b), 32'(BUBBLE)); step;
        drive_b(NOP, ADD_R1, 1'b0, 1'b0, 1'b0);
        rst_b_n = 1'b0; settle;
        check_val("b_rlu_rst_ctl", 32'(ctl_b), 32'(NORMAL));
        check_val("b_rlu_rst_cnt", if_b.stall_cnt_o, 32'd0);
        step;
        rst_b_n = 1'b1; step; settle;
        check_val("b_rlu_next_ctl", 32'(ctl_b), 32'(NORMAL));
        check_val("b_rlu_next_cnt", if_b.stall_cnt_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
